// File: rtl/mul_n_div_datapath.sv
// 4-bit shift/add multiplier and restoring divider datapath, sequenced by external op strobes; result held until res_ack.
// Optional build macro DIV_ZERO_CHK_EN: zero divisor short-circuits to DONE with div0 flagged.
module mul_n_div_datapath (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] x_in,
    input  logic [3:0] y_in,
    input  logic       ld_multiplicand,
    input  logic       ld_multiplier,
    input  logic       ld_dividend,
    input  logic       ld_divisor,
    input  logic       ad,
    input  logic       sub,
    input  logic       sh,
    input  logic       ld_subres,
    input  logic       res_ack,
    output logic       c,
    output logic       msb,
    output logic [7:0] product,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       res_valid,
    output logic       busy,
    output logic       proto_err,
    output logic       div0
);
`ifdef DIV_ZERO_CHK_EN
    localparam bit ZERO_CHK = 1'b1;
`else
    localparam bit ZERO_CHK = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, MUL, DIV, DIV_TAIL, DONE} state_t;

    state_t     state;
    logic [4:0] a, r, diff;
    logic [3:0] q, m, d;
    logic [2:0] cnt;

    logic mul_any, div_any, mul_load, div_load, load_err;
    logic multi_op, op_err, op_ok;

    always_comb begin
        mul_any  = ld_multiplicand | ld_multiplier;
        div_any  = ld_dividend | ld_divisor;
        mul_load = ld_multiplicand & ld_multiplier & ~div_any;
        div_load = ld_dividend & ld_divisor & ~mul_any;
        load_err = (mul_any | div_any) & ~mul_load & ~div_load;
        multi_op = ({1'b0, ad} + {1'b0, sub} + {1'b0, sh} + {1'b0, ld_subres}) > 2'd1;
        op_err   = 1'b0;
        case (state)
            IDLE, DONE: op_err = ad | sub | sh | ld_subres;
            MUL:        op_err = sub | ld_subres;
            DIV:        op_err = ad | (ld_subres & diff[4]);
            DIV_TAIL:   op_err = sh | (ld_subres & diff[4]);
            default:    op_err = 1'b0;
        endcase
        op_ok = ~multi_op & ~op_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            a         <= 5'd0;
            r         <= 5'd0;
            diff      <= 5'd0;
            q         <= 4'd0;
            m         <= 4'd0;
            d         <= 4'd0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
            div0      <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            if (load_err) begin
                proto_err <= 1'b1;
            end else if (mul_load) begin
                m <= x_in; q <= y_in; a <= 5'd0; cnt <= 3'd0;
                state <= MUL; busy <= 1'b1; res_valid <= 1'b0; div0 <= 1'b0;
            end else if (div_load) begin
                cnt <= 3'd0;
                if (ZERO_CHK && y_in == 4'd0) begin
                    d <= 4'd0; q <= 4'hF; r <= {1'b0, x_in};
                    state <= DONE; busy <= 1'b0; res_valid <= 1'b1; div0 <= 1'b1;
                end else begin
                    d <= y_in; q <= x_in; r <= 5'd0;
                    state <= DIV; busy <= 1'b1; res_valid <= 1'b0; div0 <= 1'b0;
                end
            end else begin
                proto_err <= ~op_ok;
                case (state)
                    MUL: if (op_ok) begin
                        if (ad) begin
                            a <= {1'b0, a[3:0]} + {1'b0, m};
                        end else if (sh) begin
                            {a, q} <= {a, q} >> 1;
                            cnt    <= cnt + 3'd1;
                            if (cnt == 3'd3) begin
                                state <= DONE; busy <= 1'b0; res_valid <= 1'b1;
                            end
                        end
                    end
                    DIV: if (op_ok) begin
                        if (sh) begin
                            {r, q} <= {r[3:0], q, 1'b0};
                            cnt    <= cnt + 3'd1;
                        end else if (sub) begin
                            diff <= r - {1'b0, d};
                            if (cnt == 3'd4) state <= DIV_TAIL;
                        end else if (ld_subres) begin
                            r    <= diff;
                            q[0] <= 1'b1;
                        end
                    end
                    // A negative final difference needs no restore step, so finish directly.
                    DIV_TAIL: begin
                        if (diff[4]) begin
                            state <= DONE; busy <= 1'b0; res_valid <= 1'b1;
                        end else if (op_ok && ld_subres) begin
                            r <= diff; q[0] <= 1'b1;
                            state <= DONE; busy <= 1'b0; res_valid <= 1'b1;
                        end
                    end
                    DONE: if (res_ack) begin
                        state <= IDLE; res_valid <= 1'b0; div0 <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign c         = q[0];
    assign msb       = diff[4];
    assign product   = {a[3:0], q};
    assign quotient  = q;
    assign remainder = r[3:0];
endmodule

// File: tb/tb_mul_n_div_datapath.sv
// Directed bench for mul_n_div_datapath: multiply, divide, divide-by-zero, protocol errors, reset and load/ack races.
module tb_mul_n_div_datapath;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] x_in, y_in;
    logic       ld_multiplicand, ld_multiplier, ld_dividend, ld_divisor;
    logic       ad, sub, sh, ld_subres, res_ack;
    logic       c, msb, res_valid, busy, proto_err, div0;
    logic [7:0] product;
    logic [3:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    mul_n_div_datapath dut (
        .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in),
        .ld_multiplicand(ld_multiplicand), .ld_multiplier(ld_multiplier),
        .ld_dividend(ld_dividend), .ld_divisor(ld_divisor),
        .ad(ad), .sub(sub), .sh(sh), .ld_subres(ld_subres), .res_ack(res_ack),
        .c(c), .msb(msb), .product(product), .quotient(quotient), .remainder(remainder),
        .res_valid(res_valid), .busy(busy), .proto_err(proto_err), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ld_multiplicand = 0; ld_multiplier = 0; ld_dividend = 0; ld_divisor = 0;
        ad = 0; sub = 0; sh = 0; ld_subres = 0; res_ack = 0;
    endtask

    task automatic do_op(input logic a_, input logic s_, input logic h_, input logic l_);
        ad = a_; sub = s_; sh = h_; ld_subres = l_;
        cyc();
        clr();
    endtask

    task automatic load_mul(input logic [3:0] x, input logic [3:0] y);
        x_in = x; y_in = y; ld_multiplicand = 1; ld_multiplier = 1;
        cyc();
        clr();
    endtask

    task automatic load_div(input logic [3:0] x, input logic [3:0] y);
        x_in = x; y_in = y; ld_dividend = 1; ld_divisor = 1;
        cyc();
        clr();
    endtask

    task automatic ack();
        res_ack = 1;
        cyc();
        clr();
    endtask

    task automatic run_mul(input int steps);
        for (int i = 0; i < steps; i++) begin
            if (c) do_op(1, 0, 0, 0);
            do_op(0, 0, 1, 0);
        end
    endtask

    task automatic run_div();
        for (int i = 0; i < 4; i++) begin
            do_op(0, 0, 1, 0);
            do_op(0, 1, 0, 0);
            if (!msb) do_op(0, 0, 0, 1);
            else if (i == 3) cyc();
        end
    endtask

    initial begin
        clr();
        x_in = 0; y_in = 0;
        rst = 1;
        cyc(); cyc();
        rst = 0;
        check("rst_product", product, 8'h00);
        check("rst_quot", quotient, 4'h0);
        check("rst_rem", remainder, 4'h0);
        check("rst_valid", res_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_perr", proto_err, 1'b0);
        check("rst_div0", div0, 1'b0);

        // op strobe while idle
        do_op(0, 0, 1, 0);
        check("idle_sh_perr", proto_err, 1'b1);
        cyc();
        check("perr_pulse", proto_err, 1'b0);

        // 13 x 11 = 143
        load_mul(4'd13, 4'd11);
        check("mul_busy", busy, 1'b1);
        run_mul(4);
        check("mul_valid", res_valid, 1'b1);
        check("mul_product", product, 8'h8F);
        check("mul_busy_done", busy, 1'b0);
        cyc(); cyc();
        check("mul_hold_valid", res_valid, 1'b1);
        check("mul_hold_product", product, 8'h8F);
        ack();
        check("mul_ack_valid", res_valid, 1'b0);
        ack();
        check("ack_idle_perr", proto_err, 1'b0);

        // 13 / 3 = 4 r 1
        load_div(4'd13, 4'd3);
        run_div();
        check("div_valid", res_valid, 1'b1);
        check("div_quot", quotient, 4'h4);
        check("div_rem", remainder, 4'h1);
        ack();

        // 9 / 0
        load_div(4'd9, 4'd0);
`ifdef DIV_ZERO_CHK_EN
        check("dz_valid", res_valid, 1'b1);
        check("dz_div0", div0, 1'b1);
`else
        run_div();
        check("dz_valid", res_valid, 1'b1);
        check("dz_div0", div0, 1'b0);
`endif
        check("dz_quot", quotient, 4'hF);
        check("dz_rem", remainder, 4'h9);
        ack();
        check("dz_div0_clear", div0, 1'b0);

        // protocol errors during division
        load_div(4'd13, 4'd3);
        do_op(1, 0, 0, 0);
        check("div_ad_perr", proto_err, 1'b1);
        check("div_ad_quot", quotient, 4'hD);
        check("div_ad_rem", remainder, 4'h0);
        do_op(0, 0, 1, 0);
        check("div_sh_perr", proto_err, 1'b0);
        do_op(0, 1, 0, 0);
        check("div_msb", msb, 1'b1);
        do_op(0, 0, 0, 1);
        check("ldsub_msb1_perr", proto_err, 1'b1);
        check("ldsub_msb1_rem", remainder, 4'h1);
        check("ldsub_msb1_quot", quotient, 4'hA);
        do_op(0, 1, 1, 0);
        check("shsub_perr", proto_err, 1'b1);
        check("shsub_quot", quotient, 4'hA);
        check("shsub_rem", remainder, 4'h1);
        cyc();
        check("shsub_pulse", proto_err, 1'b0);

        // reset in the middle of a multiply
        load_mul(4'd15, 4'd15);
        run_mul(2);
        check("mid_product", product, 8'hB7);
        rst = 1;
        cyc();
        rst = 0;
        check("midrst_product", product, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", res_valid, 1'b0);
        load_mul(4'd15, 4'd15);
        run_mul(4);
        check("mul15_valid", res_valid, 1'b1);
        check("mul15_product", product, 8'hE1);

        // partial load pair in DONE
        ld_multiplicand = 1; x_in = 4'd2;
        cyc(); clr();
        check("partial_perr", proto_err, 1'b1);
        check("partial_valid", res_valid, 1'b1);
        check("partial_product", product, 8'hE1);

        // ack and new load together: load wins
        res_ack = 1; ld_multiplicand = 1; ld_multiplier = 1; x_in = 4'd2; y_in = 4'd3;
        cyc(); clr();
        check("race_valid", res_valid, 1'b0);
        check("race_busy", busy, 1'b1);
        check("race_product", product, 8'h03);
        run_mul(4);
        check("race_done_product", product, 8'h06);
        check("race_done_valid", res_valid, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
